// File: rtl/scabbard_ctrl_pkg.sv
// Shared definitions for the polynomial-multiplier sequencer:
// command mode encodings, FSM state encodings and a width helper.
package scabbard_ctrl_pkg;

    localparam logic [1:0] MODE_MV   = 2'd0;
    localparam logic [1:0] MODE_MVT  = 2'd1;
    localparam logic [1:0] MODE_IP   = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MUL_ISSUE = 3'd1;
    localparam logic [2:0] ST_MUL_WAIT  = 3'd2;
    localparam logic [2:0] ST_WB_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WB_WAIT   = 3'd4;

    // Ceiling log2, used to confirm IDX_W can address L*L polynomials.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/poly_mul_seq_ctrl_if.sv
// Command handshake and multiplier control bus of the sequencer.
// slave is the sequencer's view; master is the host/multiplier side.
interface poly_mul_seq_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             cmd_valid;
    logic [1:0]       cmd_mode;
    logic             cmd_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic             mul_start;
    logic             mul_wb;
    logic             mul_done;
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] s_idx;
    logic [IDX_W-1:0] res_idx;

    modport slave (
        input  cmd_valid, cmd_mode, mul_done,
        output cmd_ready, busy, done, err, mul_start, mul_wb,
        output a_idx, s_idx, res_idx
    );

    modport master (
        output cmd_valid, cmd_mode, mul_done,
        input  cmd_ready, busy, done, err, mul_start, mul_wb,
        input  a_idx, s_idx, res_idx
    );
endinterface

// File: rtl/poly_idx_gen.sv
// Row/column counters of the sequencer and the mapping from (i, j)
// to operand and result polynomial indices. Index outputs are
// registered and only move when a counter control is asserted, so
// they stay stable across a whole multiplier operation.
module poly_idx_gen
    import scabbard_ctrl_pkg::*;
#(
    parameter int L     = 3,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc_i,
    input  logic             inc_j,
    input  logic [1:0]       mode,
    output logic [IDX_W-1:0] a_idx,
    output logic [IDX_W-1:0] s_idx,
    output logic [IDX_W-1:0] res_idx,
    output logic             i_last,
    output logic             j_last
);

    localparam logic [IDX_W-1:0] L_W = IDX_W'(L);

    logic [IDX_W-1:0] i_cnt;
    logic [IDX_W-1:0] j_cnt;
    logic [IDX_W-1:0] i_nxt;
    logic [IDX_W-1:0] j_nxt;
    logic [IDX_W-1:0] a_nxt;

    // Next row/column: clear wins, a row step restarts the column.
    always_comb begin
        i_nxt = i_cnt;
        j_nxt = j_cnt;
        if (clr) begin
            i_nxt = '0;
            j_nxt = '0;
        end else if (inc_i) begin
            i_nxt = i_cnt + 1'b1;
            j_nxt = '0;
        end else if (inc_j) begin
            j_nxt = j_cnt + 1'b1;
        end
    end

    // Matrix/vector operand index: row-major, column-major or vector.
    always_comb begin
        case (mode)
            MODE_MV:  a_nxt = i_nxt * L_W + j_nxt;
            MODE_MVT: a_nxt = j_nxt * L_W + i_nxt;
            default:  a_nxt = j_nxt;
        endcase
    end

    // Counter and index registers, updated only on a counter step.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_cnt   <= '0;
            j_cnt   <= '0;
            a_idx   <= '0;
            s_idx   <= '0;
            res_idx <= '0;
        end else if (clr || inc_i || inc_j) begin
            i_cnt   <= i_nxt;
            j_cnt   <= j_nxt;
            a_idx   <= a_nxt;
            s_idx   <= j_nxt;
            res_idx <= i_nxt;
        end
    end

    assign j_last = (j_cnt == L_W - 1'b1);
    assign i_last = (mode == MODE_IP) ? (i_cnt == '0) : (i_cnt == L_W - 1'b1);

endmodule

// File: rtl/poly_mul_seq_ctrl.sv
// Sequencer for the schoolbook polynomial multiplier: expands one
// matrix-vector, transposed matrix-vector or inner-product command into
// start (multiply-accumulate) and write-back pulses, with a watchdog on
// every multiplier wait. All outputs are registered.
module poly_mul_seq_ctrl
    import scabbard_ctrl_pkg::*;
#(
    parameter int L     = 3,
    parameter int IDX_W = 4,
    parameter int TO_W  = 10
) (
    input  logic                clk,
    input  logic                resetn,
    poly_mul_seq_ctrl_if.slave  bus
);

    if (IDX_W < clog2(L * L)) begin : g_idx_w_check
        $error("poly_mul_seq_ctrl: IDX_W too narrow for L*L polynomials");
    end
    if (L < 1 || L > 4) begin : g_rank_check
        $error("poly_mul_seq_ctrl: L must be in 1..4");
    end

    localparam logic [TO_W-1:0] WD_MAX = '1;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [1:0]      mode_q;
    logic [1:0]      mode_sel;
    logic [TO_W-1:0] wd_cnt;
    logic            in_wait;
    logic            wd_expired;
    logic            done_nxt;
    logic            err_nxt;
    logic            idx_clr;
    logic            inc_i;
    logic            inc_j;
    logic            i_last;
    logic            j_last;
    logic            cmd_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            start_q;
    logic            wb_q;

    assign in_wait    = (state == ST_MUL_WAIT) || (state == ST_WB_WAIT);
    assign wd_expired = in_wait && (wd_cnt == WD_MAX);
    // While idle the incoming mode drives the index mapping for the accept.
    assign mode_sel   = (state == ST_IDLE) ? bus.cmd_mode : mode_q;

    poly_idx_gen #(
        .L     (L),
        .IDX_W (IDX_W)
    ) u_idx_gen (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (idx_clr),
        .inc_i   (inc_i),
        .inc_j   (inc_j),
        .mode    (mode_sel),
        .a_idx   (bus.a_idx),
        .s_idx   (bus.s_idx),
        .res_idx (bus.res_idx),
        .i_last  (i_last),
        .j_last  (j_last)
    );

    // Next-state decode; mul_done takes priority over a watchdog expiry.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        idx_clr   = 1'b0;
        inc_i     = 1'b0;
        inc_j     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_mode == MODE_RSVD) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_MUL_ISSUE;
                        idx_clr   = 1'b1;
                    end
                end
            end
            ST_MUL_ISSUE: state_nxt = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (bus.mul_done) begin
                    if (j_last) begin
                        state_nxt = ST_WB_ISSUE;
                    end else begin
                        state_nxt = ST_MUL_ISSUE;
                        inc_j     = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            ST_WB_ISSUE: state_nxt = ST_WB_WAIT;
            ST_WB_WAIT: begin
                if (bus.mul_done) begin
                    if (i_last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_MUL_ISSUE;
                        inc_i     = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, latched mode and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_MV;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            wb_q        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= (state_nxt == ST_IDLE);
            busy_q      <= (state_nxt != ST_IDLE);
            start_q     <= (state_nxt == ST_MUL_ISSUE);
            wb_q        <= (state_nxt == ST_WB_ISSUE);
            done_q      <= done_nxt;
            err_q       <= err_nxt;
            if (idx_clr) begin
                mode_q <= bus.cmd_mode;
            end
        end
    end

    // Watchdog: counts consecutive wait cycles, restarts on any state change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
        end else if (in_wait && (state_nxt == state)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mul_start = start_q;
    assign bus.mul_wb    = wb_q;

endmodule

// File: tb/tb_poly_mul_seq_ctrl.sv
// Bench for poly_mul_seq_ctrl: a multiplier model answers pulses with
// fixed latencies, a monitor logs every pulse, and each command's log is
// compared against the index order and timing the command should produce.
module tb_poly_mul_seq_ctrl;

    localparam int L       = 3;
    localparam int IDX_W   = 4;
    localparam int TO_W    = 10;
    localparam int MUL_LAT = 290;
    localparam int WB_LAT  = 513;
    localparam int BOUND   = 8000;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    poly_mul_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();

    poly_mul_seq_ctrl #(
        .L     (L),
        .IDX_W (IDX_W),
        .TO_W  (TO_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    int st_a[$];
    int st_s[$];
    int st_cyc[$];
    int wb_r[$];
    int done_cyc[$];
    int err_cyc[$];
    int hold_bad    = 0;
    int overlap     = 0;
    int ready_bad   = 0;
    int st_total    = 0;
    int withhold_at = 0;
    int stray_req   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Multiplier model and pulse monitor, evaluated on the falling edge.
    initial begin
        int  cnt;
        int  stray_seen;
        bit  kind;
        int  hold_a;
        int  hold_s;
        int  hold_r;
        cnt = 0; stray_seen = 0; kind = 1'b0; hold_a = 0; hold_s = 0; hold_r = 0;
        bus.mul_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                cnt = 0;
                bus.mul_done = 1'b0;
            end else begin
                if (bus.mul_start) begin
                    st_a.push_back(int'(bus.a_idx));
                    st_s.push_back(int'(bus.s_idx));
                    st_cyc.push_back(cyc);
                    hold_a = int'(bus.a_idx);
                    hold_s = int'(bus.s_idx);
                end
                if (bus.mul_wb) begin
                    wb_r.push_back(int'(bus.res_idx));
                    hold_r = int'(bus.res_idx);
                end
                if (bus.done) done_cyc.push_back(cyc);
                if (bus.err) err_cyc.push_back(cyc);
                if (bus.done && bus.err) overlap++;
                if ((bus.done || bus.err) && !bus.cmd_ready) ready_bad++;
                bus.mul_done = 1'b0;
                if (stray_seen != stray_req) begin
                    stray_seen++;
                    bus.mul_done = 1'b1;
                end
                if (bus.mul_start) begin
                    st_total++;
                    kind = 1'b0;
                    cnt = (st_total == withhold_at) ? 0 : MUL_LAT;
                end else if (bus.mul_wb) begin
                    kind = 1'b1;
                    cnt = WB_LAT;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (kind ? (int'(bus.res_idx) != hold_r)
                                 : (int'(bus.a_idx) != hold_a || int'(bus.s_idx) != hold_s))
                            hold_bad++;
                        bus.mul_done = 1'b1;
                    end
                end
            end
        end
    end

    // One command end to end; the expected pulse order comes from the mode rules.
    task automatic run_cmd(input logic [1:0] m, input bit hold, input bit withhold);
        int ea[$];
        int es[$];
        int er[$];
        int b_st, b_wb, b_dn, b_er, b_hb, b_ov, b_rb;
        int acc, rows, n_st, n_wb, k, d;
        bit timed_out;
        b_st = st_a.size(); b_wb = wb_r.size(); b_dn = done_cyc.size();
        b_er = err_cyc.size(); b_hb = hold_bad; b_ov = overlap; b_rb = ready_bad;
        rows = (m == 2'd2) ? 1 : L;
        if (m != 2'd3) begin
            for (int i = 0; i < rows; i++) begin
                for (int j = 0; j < L; j++) begin
                    ea.push_back(m == 2'd0 ? i * L + j : (m == 2'd1 ? j * L + i : j));
                    es.push_back(j);
                end
                er.push_back(i);
            end
        end
        withhold_at = withhold ? st_total + 4 : 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        acc = cyc;
        @(negedge clk);
        if (hold) begin
            bus.cmd_mode = 2'($urandom_range(0, 3));
            k = 0;
            while (wb_r.size() == b_wb && k < BOUND) begin
                @(negedge clk);
                k++;
            end
        end
        bus.cmd_valid = 1'b0;
        timed_out = 1'b1;
        for (int t = 0; t < BOUND; t++) begin
            if (done_cyc.size() != b_dn || err_cyc.size() != b_er) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        withhold_at = 0;
        check_eq("cmd_completes", timed_out, 0);
        if (m == 2'd3) begin
            check_eq("rsvd_err_count", err_cyc.size() - b_er, 1);
            if (err_cyc.size() > b_er) check_eq("rsvd_err_cycle", err_cyc[b_er], acc + 1);
            check_eq("rsvd_starts", st_a.size() - b_st, 0);
            check_eq("rsvd_wbs", wb_r.size() - b_wb, 0);
            check_eq("rsvd_done", done_cyc.size() - b_dn, 0);
        end else begin
            n_st = withhold ? 4 : ea.size();
            n_wb = withhold ? 1 : er.size();
            check_eq("start_count", st_a.size() - b_st, n_st);
            check_eq("wb_count", wb_r.size() - b_wb, n_wb);
            for (int q = 0; q < n_st && b_st + q < st_a.size(); q++) begin
                check_eq("start_a_idx", st_a[b_st + q], ea[q]);
                check_eq("start_s_idx", st_s[b_st + q], es[q]);
            end
            for (int q = 0; q < n_wb && b_wb + q < wb_r.size(); q++)
                check_eq("wb_res_idx", wb_r[b_wb + q], er[q]);
            if (st_a.size() > b_st) check_eq("first_start_cycle", st_cyc[b_st], acc + 1);
            if (withhold) begin
                check_eq("wd_err_count", err_cyc.size() - b_er, 1);
                check_eq("wd_no_done", done_cyc.size() - b_dn, 0);
                if (err_cyc.size() > b_er && st_a.size() >= b_st + 4) begin
                    d = err_cyc[b_er] - st_cyc[b_st + 3];
                    check_eq("wd_delay_in_window", (d >= 1020 && d <= 1030), 1);
                end
            end else begin
                check_eq("done_count", done_cyc.size() - b_dn, 1);
                check_eq("no_err", err_cyc.size() - b_er, 0);
                if (done_cyc.size() > b_dn)
                    check_eq("done_cycle", done_cyc[b_dn],
                             acc + 1 + n_st * (MUL_LAT + 1) + n_wb * (WB_LAT + 1));
            end
        end
        check_eq("end_busy", bus.busy, 0);
        check_eq("end_cmd_ready", bus.cmd_ready, 1);
        check_eq("idx_held_until_done", hold_bad - b_hb, 0);
        check_eq("done_err_overlap", overlap - b_ov, 0);
        check_eq("ready_with_done_err", ready_bad - b_rb, 0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_mul_start", bus.mul_start, 0);
        check_eq("rst_mul_wb", bus.mul_wb, 0);
        check_eq("rst_a_idx", bus.a_idx, 0);
        check_eq("rst_s_idx", bus.s_idx, 0);
        check_eq("rst_res_idx", bus.res_idx, 0);
    endtask

    initial begin
        int b_st, b_wb, b_dn, b_er, k, m, gap;
        bit hold;
        resetn = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 2'd0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(2'd0, 1'b0, 1'b0);
        run_cmd(2'd1, 1'b0, 1'b0);
        run_cmd(2'd2, 1'b0, 1'b0);
        run_cmd(2'd3, 1'b0, 1'b0);
        run_cmd(2'd0, 1'b0, 1'b1);

        // Stray mul_done while idle.
        b_st = st_a.size(); b_wb = wb_r.size(); b_dn = done_cyc.size(); b_er = err_cyc.size();
        stray_req++;
        repeat (6) @(negedge clk);
        check_eq("stray_starts", st_a.size() - b_st, 0);
        check_eq("stray_wbs", wb_r.size() - b_wb, 0);
        check_eq("stray_done_err", (done_cyc.size() - b_dn) + (err_cyc.size() - b_er), 0);
        check_eq("stray_cmd_ready", bus.cmd_ready, 1);

        // cmd_valid held while busy executes once.
        run_cmd(2'd2, 1'b1, 1'b0);

        // Reset in WB_WAIT of the second row.
        b_wb = wb_r.size(); b_dn = done_cyc.size();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 2'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (wb_r.size() < b_wb + 2 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_reached_wb_wait", wb_r.size() - b_wb, 2);
        repeat (10) @(negedge clk);
        check_eq("pre_rst_busy", bus.busy, 1);
        #2 resetn = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        check_eq("rst_no_done", done_cyc.size() - b_dn, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(2'd0, 1'b0, 1'b0);

        // Randomized command mix with idle gaps.
        for (int r = 0; r < 3; r++) begin
            m    = $urandom_range(0, 3);
            gap  = $urandom_range(0, 4);
            hold = (m != 3) && ($urandom_range(0, 1) == 1);
            repeat (gap) @(negedge clk);
            run_cmd(2'(m), hold, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
